pulse_period_meter: RTL and testbench

Measures the spacing between rising edges of a pulse or tick input, counted in i_clk cycles. It is the receive-side counterpart to the team's programmable tick dividers. It reports the divider setting that produced the tick: a tick every N+1 cycles reads back as N. It is used for self-check of divider configuration and for measuring external strobe rates on the CYC1000 template.

---
 rtl/pulse_period_meter_pkg.sv | 17 +
 rtl/pulse_edge_sync.sv | 40 ++++
 rtl/pulse_period_meter.sv | 88 ++++++++
 tb/tb_pulse_period_meter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pulse_period_meter_pkg.sv
// Shared types and defaults for the pulse period meter.
// Latency: n/a; backpressure: n/a (types and constants only).
package pulse_period_meter_pkg;

  localparam int unsigned CNT_W_DEF = 24;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    TIMEOUT = 2'd2
  } state_e;

  function automatic logic state_is_busy(input state_e s);
    return (s == RUN);
  endfunction

endpackage

// File: rtl/pulse_edge_sync.sv
// Rising-edge detector on i_pulse, optionally behind a 2-flop synchronizer (PULSE_PERIOD_METER_SYNC_EN).
// Latency: o_rise combinational from the sampled pulse (+2 cycles with sync); backpressure: none.
module pulse_edge_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_pulse,
  output logic o_rise
);

  logic sampled;
  logic prev_q;

`ifdef PULSE_PERIOD_METER_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], i_pulse};
    end
  end

  assign sampled = sync_q[1];
`else
  assign sampled = i_pulse;
`endif

  // History updates in every state so a level held through a clear never looks like a new edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sampled;
    end
  end

  assign o_rise = sampled & ~prev_q;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures rising-edge spacing of i_pulse in i_clk cycles, reporting spacing-1; sync option PULSE_PERIOD_METER_SYNC_EN.
// Latency: o_valid one cycle after the rise is sampled (+2 with sync); backpressure: none, o_valid is a strobe.
module pulse_period_meter
  import pulse_period_meter_pkg::*;
#(
  parameter int unsigned      CNT_W       = CNT_W_DEF,
  parameter logic [CNT_W-1:0] TIMEOUT_MAX = '1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_pulse,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_period,
  output logic             o_valid,
  output logic             o_timeout,
  output logic             o_busy
);

  logic             rise;
  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] period_q;
  logic             valid_q;
  logic             timeout_q;

  pulse_edge_sync u_edge (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_pulse (i_pulse),
    .o_rise  (rise)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else if (i_clear) begin
      state_q   <= IDLE;
      count_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          count_q <= '0;
          if (rise) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          // A rise landing on the timeout cycle still counts as a measurement.
          if (rise) begin
            period_q <= count_q;
            valid_q  <= 1'b1;
            count_q  <= '0;
          end else if (count_q == TIMEOUT_MAX) begin
            state_q   <= TIMEOUT;
            timeout_q <= 1'b1;
            count_q   <= '0;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        TIMEOUT: begin
          count_q <= '0;
          if (rise) begin
            state_q   <= RUN;
            timeout_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          count_q <= '0;
        end
      endcase
    end
  end

  assign o_period  = period_q;
  assign o_valid   = valid_q;
  assign o_timeout = timeout_q;
  assign o_busy    = state_is_busy(state_q);

endmodule

// File: tb/tb_pulse_period_meter.sv
// Scoreboard bench for pulse_period_meter with TIMEOUT_MAX=15.
// Expected periods are pushed as edges are driven and popped when o_valid fires.
module tb_pulse_period_meter;

  localparam int CW   = 24;
  localparam int TMAX = 15;
`ifdef PULSE_PERIOD_METER_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pulse = 1'b0;
  logic          clr = 1'b0;
  logic [CW-1:0] period;
  logic          valid;
  logic          tmo;
  logic          busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_edge = 0;
  bit have_ref = 1'b0;
  int exp_last = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  pulse_period_meter #(
    .CNT_W       (CW),
    .TIMEOUT_MAX (24'd15)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_pulse   (pulse),
    .i_clear   (clr),
    .o_period  (period),
    .o_valid   (valid),
    .o_timeout (tmo),
    .o_busy    (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Edge spacing S gives S-1; a spacing too long to measure means the DUT timed out and
  // this edge only re-arms the measurement.
  task automatic model_edge();
    int gap;
    gap = cyc - last_edge;
    if (have_ref && (gap - 1) <= TMAX) begin
      exp_q.push_back(gap - 1);
      exp_last = gap - 1;
    end
    have_ref  = 1'b1;
    last_edge = cyc;
  endtask

  task automatic send_pulse(input int gap);
    model_edge();
    pulse = 1'b1;
    tick();
    pulse = 1'b0;
    repeat (gap - 1) tick();
  endtask

  always @(negedge clk) begin
    if (!rst && valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("valid_unexpected", 32'd1, 32'd0);
      end else begin
        chk("period", {8'd0, period}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_period", {8'd0, period}, 0);
    chk("rst_valid", {31'd0, valid}, 0);
    chk("rst_timeout", {31'd0, tmo}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("idle_busy", {31'd0, busy}, 0);

    // Divider N=4, then N=10 mid-stream
    repeat (4) send_pulse(5);
    chk("busy_run", {31'd0, busy}, 1);
    repeat (4) send_pulse(11);

    // Edges stop: timeout lands exactly 16 cycles after the last sampled edge
    send_pulse(1);
    repeat (15 + L) tick();
    chk("tmo_early", {31'd0, tmo}, 0);
    tick();
    chk("tmo_set", {31'd0, tmo}, 1);
    chk("tmo_period_hold", {8'd0, period}, exp_last);
    chk("tmo_busy", {31'd0, busy}, 0);
    send_pulse(7);
    chk("tmo_cleared", {31'd0, tmo}, 0);
    chk("tmo_rearm_busy", {31'd0, busy}, 1);
    send_pulse(7);
    send_pulse(7);

    // Spacing exactly TIMEOUT_MAX+1 is still measured
    repeat (4) send_pulse(16);
    send_pulse(5);
    chk("boundary_no_tmo", {31'd0, tmo}, 0);

    // Async reset mid-count with the pulse level held high across release
    pulse = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst_period", {8'd0, period}, 0);
    chk("arst_valid", {31'd0, valid}, 0);
    chk("arst_timeout", {31'd0, tmo}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_q_empty", exp_q.size(), 0);
    have_ref = 1'b0;
    tick();
    tick();
    #3 rst = 1'b0;
    repeat (20) tick();
    pulse = 1'b0;
    repeat (3) tick();
    repeat (3) send_pulse(9);
    chk("post_rst_tmo", {31'd0, tmo}, 0);

    // Soft clear in RUN with the pulse held high
    model_edge();
    pulse = 1'b1;
    tick();
    repeat (3 + L) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    have_ref = 1'b0;
    chk("clr_busy", {31'd0, busy}, 0);
    chk("clr_valid", {31'd0, valid}, 0);
    chk("clr_timeout", {31'd0, tmo}, 0);
    chk("clr_period_hold", {8'd0, period}, exp_last);
    repeat (5) tick();
    chk("clr_level_no_rise", {31'd0, busy}, 0);
    pulse = 1'b0;
    repeat (3) tick();
    chk("clr_low_idle", {31'd0, busy}, 0);
    repeat (3) send_pulse(8);
    repeat (20) tick();
    chk("final_tmo", {31'd0, tmo}, 1);
    chk("final_period", {8'd0, period}, 7);
    chk("q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
